// File: rtl/atctlc2axi500_burst_splitter.sv
// Splits one bridge request into AXI sub-bursts of at most MAX_BEATS beats that never cross a 4KB page.
// state | meaning
// IDLE  | waiting for a request, i_ready high
// BUSY  | a sub-burst is presented on the output, waiting for o_ready
module atctlc2axi500_burst_splitter #(
   parameter int AW          = 32,
   parameter int LW          = 8,
   parameter int UW          = 4,
   parameter int MAX_BEATS   = 16,
   parameter int RAR_SUPPORT = 0
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic [AW-1:0] i_addr,
   input  logic [LW-1:0] i_len,
   input  logic [2:0]    i_size,
   input  logic [UW-1:0] i_user,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [AW-1:0] o_addr,
   output logic [7:0]    o_len,
   output logic [2:0]    o_size,
   output logic [UW-1:0] o_user,
   output logic          o_last
);

   localparam int RW = LW + 1;
   localparam int NW = (RW > 13) ? RW : 13;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [RW-1:0]   r_rem;
   logic            r_last;
   logic [AW-1:0]   r_addr;
   logic [7:0]      r_len;
   logic [2:0]      r_size;
   logic [UW-1:0]   r_user;

   logic            w_hs;
   logic            w_done;
   logic            w_advance;
   logic            w_accept;
   logic            w_load;
   logic [8:0]      w_cur_n;
   logic [AW-1:0]   w_cur_mask;
   logic [AW-1:0]   w_next_addr;
   logic [AW-1:0]   w_src_addr;
   logic [2:0]      w_src_size;
   logic [RW-1:0]   w_src_rem;
   logic [11:0]     w_src_mask;
   logic [11:0]     w_src_page_off;
   logic [12:0]     w_b4k;
   logic [NW-1:0]   w_n;
   logic [7:0]      w_len;
   logic            w_last;

   assign w_hs      = (r_state == S_BUSY) && o_ready;
   assign w_done    = w_hs && r_last;
   assign w_advance = w_hs && !r_last;
   assign i_ready   = (r_state == S_IDLE) || w_done;
   assign w_accept  = i_valid && i_ready;
   assign w_load    = w_accept || w_advance;

   // Later sub-bursts always restart from the size-aligned address of the current one.
   assign w_cur_n     = {1'b0, r_len} + 9'd1;
   assign w_cur_mask  = ~((AW'(1) << r_size) - AW'(1));
   assign w_next_addr = (r_addr & w_cur_mask) + (AW'(w_cur_n) << r_size);

   assign w_src_addr = w_accept ? i_addr : w_next_addr;
   assign w_src_size = w_accept ? i_size : r_size;
   assign w_src_rem  = w_accept ? (RW'(i_len) + RW'(1)) : (r_rem - RW'(w_cur_n));

   assign w_src_mask     = ~((12'd1 << w_src_size) - 12'd1);
   assign w_src_page_off = w_src_addr[11:0] & w_src_mask;
   assign w_b4k          = (13'h1000 - {1'b0, w_src_page_off}) >> w_src_size;

   always_comb begin
      w_n = NW'(w_src_rem);
      if (w_n > NW'(MAX_BEATS)) w_n = NW'(MAX_BEATS);
      if (w_n > NW'(w_b4k))     w_n = NW'(w_b4k);
   end

   assign w_len  = 8'(w_n - NW'(1));
   assign w_last = (NW'(w_src_rem) == w_n);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
         S_BUSY:  if (w_done && !w_accept) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rem  <= '0;
         r_last <= 1'b0;
      end else if (w_load) begin
         r_rem  <= w_src_rem;
         r_last <= w_last;
      end
   end

   generate
      if (RAR_SUPPORT != 0) begin : g_dp_rst
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               r_addr <= '0;
               r_len  <= '0;
               r_size <= '0;
               r_user <= '0;
            end else if (w_load) begin
               r_addr <= w_src_addr;
               r_len  <= w_len;
               r_size <= w_src_size;
               r_user <= w_accept ? i_user : r_user;
            end
         end
      end else begin : g_dp_norst
         always_ff @(posedge clk) begin
            if (w_load) begin
               r_addr <= w_src_addr;
               r_len  <= w_len;
               r_size <= w_src_size;
               r_user <= w_accept ? i_user : r_user;
            end
         end
      end
   endgenerate

   assign o_valid = (r_state == S_BUSY);
   assign o_addr  = r_addr;
   assign o_len   = r_len;
   assign o_size  = r_size;
   assign o_user  = r_user;
   assign o_last  = r_last;

endmodule

// File: tb/tb_atctlc2axi500_burst_splitter.sv
// Directed bench for the burst splitter: a table of requests with their expected sub-bursts,
// followed by back-pressure, back-to-back and mid-burst reset sequences.
module tb_atctlc2axi500_burst_splitter;

   logic        clk;
   logic        resetn;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] i_addr;
   logic [7:0]  i_len;
   logic [2:0]  i_size;
   logic [3:0]  i_user;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_addr;
   logic [7:0]  o_len;
   logic [2:0]  o_size;
   logic [3:0]  o_user;
   logic        o_last;

   int n_chk  = 0;
   int n_fail = 0;

   atctlc2axi500_burst_splitter #(
      .AW(32), .LW(8), .UW(4), .MAX_BEATS(16), .RAR_SUPPORT(0)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_addr  (i_addr),
      .i_len   (i_len),
      .i_size  (i_size),
      .i_user  (i_user),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_addr  (o_addr),
      .o_len   (o_len),
      .o_size  (o_size),
      .o_user  (o_user),
      .o_last  (o_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [3:0]        user;
      int                nsub;
      logic [3:0][31:0]  ea;
      logic [3:0][7:0]   el;
   } vec_t;

   vec_t tbl[8];

   function automatic vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                               input logic [3:0] u, input int n,
                               input logic [31:0] a0, input logic [7:0] l0,
                               input logic [31:0] a1, input logic [7:0] l1,
                               input logic [31:0] a2, input logic [7:0] l2);
      vec_t v;
      v.addr = a; v.len = l; v.size = s; v.user = u; v.nsub = n;
      v.ea[0] = a0; v.el[0] = l0;
      v.ea[1] = a1; v.el[1] = l1;
      v.ea[2] = a2; v.el[2] = l2;
      v.ea[3] = 32'h0; v.el[3] = 8'h0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Presents a request at a negedge; it is accepted on the following posedge.
   task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [3:0] u);
      @(negedge clk);
      i_addr = a; i_len = l; i_size = s; i_user = u; i_valid = 1'b1;
      chk("accept_ready", 64'(i_ready), 64'd1);
      @(posedge clk);
      #1 i_valid = 1'b0;
   endtask

   task automatic expect_sub(input string tag, input logic [31:0] ea, input logic [7:0] el,
                             input logic elast, input logic [2:0] es, input logic [3:0] eu);
      @(negedge clk);
      chk({tag, "_valid"}, 64'(o_valid), 64'd1);
      chk({tag, "_addr"},  64'(o_addr),  64'(ea));
      chk({tag, "_len"},   64'(o_len),   64'(el));
      chk({tag, "_last"},  64'(o_last),  64'(elast));
      chk({tag, "_size"},  64'(o_size),  64'(es));
      chk({tag, "_user"},  64'(o_user),  64'(eu));
   endtask

   task automatic expect_idle(input string tag);
      @(negedge clk);
      chk({tag, "_idle_valid"}, 64'(o_valid), 64'd0);
      chk({tag, "_idle_ready"}, 64'(i_ready), 64'd1);
   endtask

   initial begin
      // 0xFFA aligns to 0xFF8 for the page math, so both beats fit below the 4KB line.
      tbl[0] = mk(32'h0000_1000, 8'd3,  3'd2, 4'h1, 1, 32'h1000, 8'd3,  32'h0,    8'd0,  32'h0,    8'd0);
      tbl[1] = mk(32'h0000_0FF8, 8'd7,  3'd2, 4'h2, 2, 32'h0FF8, 8'd1,  32'h1000, 8'd5,  32'h0,    8'd0);
      tbl[2] = mk(32'h0000_2000, 8'd39, 3'd3, 4'h3, 3, 32'h2000, 8'd15, 32'h2080, 8'd15, 32'h2100, 8'd7);
      tbl[3] = mk(32'h0000_0FFA, 8'd1,  3'd2, 4'h4, 1, 32'h0FFA, 8'd1,  32'h0,    8'd0,  32'h0,    8'd0);
      tbl[4] = mk(32'h0000_1FFE, 8'd4,  3'd0, 4'h5, 2, 32'h1FFE, 8'd1,  32'h2000, 8'd2,  32'h0,    8'd0);
      tbl[5] = mk(32'h0000_3002, 8'd0,  3'd1, 4'h6, 1, 32'h3002, 8'd0,  32'h0,    8'd0,  32'h0,    8'd0);
      tbl[6] = mk(32'h0000_0FF4, 8'd3,  3'd3, 4'h7, 2, 32'h0FF4, 8'd1,  32'h1000, 8'd1,  32'h0,    8'd0);
      tbl[7] = mk(32'hFFFF_FFF8, 8'd3,  3'd2, 4'h8, 2, 32'hFFFF_FFF8, 8'd1, 32'h0000_0000, 8'd1, 32'h0, 8'd0);

      resetn = 1'b0; i_valid = 1'b0; i_addr = '0; i_len = '0; i_size = '0; i_user = '0; o_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_ready", 64'(i_ready), 64'd1);
      chk("rst_last",  64'(o_last),  64'd0);
      resetn = 1'b1;

      for (int v = 0; v < 8; v++) begin
         send(tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].user);
         for (int k = 0; k < tbl[v].nsub; k++)
            expect_sub($sformatf("v%0d_s%0d", v, k), tbl[v].ea[k], tbl[v].el[k],
                       (k == tbl[v].nsub - 1), tbl[v].size, tbl[v].user);
         expect_idle($sformatf("v%0d", v));
      end

      // Back-pressure in the middle of a three-part request.
      send(32'h2000, 8'd39, 3'd3, 4'h9);
      expect_sub("bp_s0", 32'h2000, 8'd15, 1'b0, 3'd3, 4'h9);
      @(negedge clk);
      o_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold_valid", 64'(o_valid), 64'd1);
         chk("bp_hold_addr",  64'(o_addr),  64'h2080);
         chk("bp_hold_len",   64'(o_len),   64'd15);
         chk("bp_hold_last",  64'(o_last),  64'd0);
         chk("bp_hold_iready", 64'(i_ready), 64'd0);
         @(negedge clk);
      end
      o_ready = 1'b1;
      expect_sub("bp_s2", 32'h2100, 8'd7, 1'b1, 3'd3, 4'h9);
      expect_idle("bp");

      // Second request waiting during the final handshake of the first.
      send(32'h1000, 8'd3, 3'd2, 4'h5);
      @(negedge clk);
      chk("b2b_a_addr", 64'(o_addr), 64'h1000);
      chk("b2b_a_last", 64'(o_last), 64'd1);
      i_addr = 32'h0FF8; i_len = 8'd7; i_size = 3'd2; i_user = 4'hA; i_valid = 1'b1;
      chk("b2b_ready_in_hs", 64'(i_ready), 64'd1);
      @(posedge clk);
      #1 i_valid = 1'b0;
      expect_sub("b2b_b_s0", 32'h0FF8, 8'd1, 1'b0, 3'd2, 4'hA);
      expect_sub("b2b_b_s1", 32'h1000, 8'd5, 1'b1, 3'd2, 4'hA);
      expect_idle("b2b");

      // Reset asserted during the second sub-burst.
      send(32'h2000, 8'd39, 3'd3, 4'hB);
      expect_sub("rs_s0", 32'h2000, 8'd15, 1'b0, 3'd3, 4'hB);
      expect_sub("rs_s1", 32'h2080, 8'd15, 1'b0, 3'd3, 4'hB);
      #1 resetn = 1'b0;
      #1;
      chk("rs_async_valid", 64'(o_valid), 64'd0);
      chk("rs_async_ready", 64'(i_ready), 64'd1);
      @(negedge clk);
      resetn = 1'b1;
      chk("rs_after_ready", 64'(i_ready), 64'd1);
      send(32'h0FF8, 8'd7, 3'd2, 4'hC);
      expect_sub("rs_new_s0", 32'h0FF8, 8'd1, 1'b0, 3'd2, 4'hC);
      expect_sub("rs_new_s1", 32'h1000, 8'd5, 1'b1, 3'd2, 4'hC);
      expect_idle("rs_new");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
